booth_r4_seq_multiplier: RTL and testbench
==========================================

# booth_r4_seq_multiplier

Sequential, parametrised signed multiplier built on radix-4 bit-pair (modified Booth) recoding. It retires one recoded digit per clock, so the multiplier needs WIDTH/2 cycles instead of WIDTH. It serves as the MUL execution unit beside the ALU, and the control unit reaches it through a start/busy/done handshake. The 2·WIDTH-bit product is split into HI/LO halves so the datapath can load the HI and LO registers directly.

## Interface
- WIDTH, default 32: operand width in bits. Must be even and ≥ 4.
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, synchronous and active-high.
- start  input  1  request a multiply. Sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand M, captured when start is accepted.
- multiplier  input  WIDTH  signed operand Q, captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse in DONE.
- product_hi  output  WIDTH  upper half of the signed 2·WIDTH product.
- product_lo  output  WIDTH  lower half of the signed 2·WIDTH product.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: iterates over digits.
  - DONE: pulses done.
- Reset: clr high at an edge forces the following, regardless of state, and aborts any in-flight operation:
  - state=IDLE, busy=0, done=0
  - product_hi=0, product_lo=0
  - iteration counter=0
- IDLE to RUN: start=1 at an edge. The edge captures M and Q, sets the guard bit to 0, clears the accumulator and sets the counter to 0.
- In IDLE with start=0, the block stays in IDLE.
- RUN, one digit per edge:
  - Form the triplet {Q[1], Q[0], guard}.
  - Recode it: 000/111→0, 001/010→+1, 011→+2, 100→−2, 101/110→−1.
  - Add digit·M·4^i to the 2·WIDTH accumulator. The term is sign-extended M, optionally shifted left 1 for ±2, and negated in two's complement for negative digits, then shifted left 2·i.
  - Set guard=Q[1], arithmetic-shift Q right by 2, and increment i.
- RUN to DONE: after the digit where i reaches WIDTH/2. With BOOTH_EARLY_EXIT_EN, see Configuration.
- DONE: done=1 for exactly one cycle, and the accumulator is copied to product_hi/lo on entry. The next edge returns to IDLE unconditionally.
- Arithmetic: the result is the exact signed product. Overflow is impossible, since −2^(W−1)·−2^(W−1) = 2^(2W−2) fits in 2W bits.
- start while busy is ignored and not queued. An operation is accepted only from IDLE.
- product_hi/lo hold their value from DONE until the next DONE or clr. They do not change during RUN.

## Timing
- Start accepted at edge E0. RUN edges are E1…E(WIDTH/2). DONE is entered at edge E(WIDTH/2).
- done and the valid product are visible in the cycle after E(WIDTH/2), which is WIDTH/2 cycles after acceptance.
- State returns to IDLE at edge E(WIDTH/2+1), so back-to-back issue costs WIDTH/2+2 cycles per operation.
- busy rises in the cycle after E0 and falls in the cycle after DONE exits.
- clr has priority over start on the same edge.

## Configuration
- Macro: BOOTH_EARLY_EXIT_EN.
- Defined:
  - At each RUN edge, after the shift, if the shifted Q and the new guard bit are all 0s or all 1s, every remaining digit is 0.
  - In that case the FSM goes to DONE on that edge instead of continuing.
  - Latency becomes 1…WIDTH/2 RUN cycles. The product is identical.
- Undefined: RUN always takes exactly WIDTH/2 cycles. The latency is fixed and data-independent.

## Test plan
- WIDTH=8, M=7, Q=3: product {hi,lo}=16'h0015.
  - Without the macro, done appears 4 cycles after acceptance.
  - With BOOTH_EARLY_EXIT_EN, done appears after 2 cycles (digits −1, +1, then exit).
- WIDTH=8, M=−128, Q=−128: product 16'h4000. WIDTH=8, M=127, Q=−1: product 16'hFF81. Both use fixed latency 4 without the macro.
- WIDTH=8, Q=0 with any M: product 0. With the macro, done appears after 1 RUN cycle.
- start pulsed again during RUN with different operands: ignored. The first product completes correctly and busy stays high with no extra done pulse.
- clr asserted on the second RUN edge of an operation: the next cycle shows busy=0, done=0 and products 0. A new start then completes with the correct result.
- WIDTH=32, randomised directed pairs, including M=Q=0x80000000 → {hi,lo}=64'h4000_0000_0000_0000: all results match the signed reference and done arrives exactly 16 cycles after acceptance without the macro.

Source files
------------

// File: rtl/booth_r4_seq_multiplier.sv
// Radix-4 modified-Booth sequential signed multiplier, one digit per clock.
// Ports: clk, clr (sync high), start, multiplicand, multiplier -> busy, done, product_hi/lo.
// Define BOOTH_EARLY_EXIT_EN to finish once every remaining digit recodes to zero.
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic             guard;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [2:0]       triplet;
  logic             neg;
  logic             two;
  logic             zero;
  logic [PW-1:0]    m_ext;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    term_base;
  logic [PW-1:0]    term;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             last;
  logic             finish;

  assign triplet = {q[1:0], guard};

  always_comb begin
    neg  = 1'b0;
    two  = 1'b0;
    zero = 1'b0;
    unique case (triplet)
      3'b000: zero = 1'b1;
      3'b111: zero = 1'b1;
      3'b001: ;
      3'b010: ;
      3'b011: two = 1'b1;
      3'b100: begin
        two = 1'b1;
        neg = 1'b1;
      end
      3'b101: neg = 1'b1;
      3'b110: neg = 1'b1;
      default: zero = 1'b1;
    endcase
  end

  assign m_ext     = {{WIDTH{m[WIDTH-1]}}, m};
  assign mag       = two ? (m_ext << 1) : m_ext;
  assign term_base = zero ? '0 : (neg ? (~mag + 1'b1) : mag);
  // Digit i weighs 4^i, i.e. a left shift of 2*i.
  assign term      = term_base << {cnt, 1'b0};
  assign acc_nxt   = acc + term;
  assign q_nxt     = WIDTH'($signed(q) >>> 2);
  assign cnt_nxt   = cnt + CW'(1);
  assign last      = (cnt_nxt == CW'(HALF));

`ifdef BOOTH_EARLY_EXIT_EN
  // Remaining Q plus new guard all-equal means every later triplet is 000/111.
  assign finish = last
                | (&{q_nxt, q[1]})
                | ~(|{q_nxt, q[1]});
`else
  assign finish = last;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      cnt        <= '0;
      m          <= '0;
      q          <= '0;
      guard      <= 1'b0;
      acc        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            guard <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          q     <= q_nxt;
          guard <= q[1];
          cnt   <= cnt_nxt;
          if (finish) begin
            product_hi <= acc_nxt[PW-1:WIDTH];
            product_lo <= acc_nxt[WIDTH-1:0];
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Scoreboard bench for booth_r4_seq_multiplier at WIDTH=8 and WIDTH=32.
// Drivers push expected products/latencies; per-DUT monitors check on done.
module tb_booth_r4_seq_multiplier;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  m8 = '0;
  logic [7:0]  q8 = '0;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  logic        start32 = 1'b0;
  logic [31:0] m32 = '0;
  logic [31:0] q32 = '0;
  logic        busy32;
  logic        done32;
  logic [31:0] hi32;
  logic [31:0] lo32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb8[$];
  exp_t sb32[$];

  booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8),
    .product_hi(hi8), .product_lo(lo8)
  );

  booth_r4_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .clr(clr), .start(start32),
    .multiplicand(m32), .multiplier(q32),
    .busy(busy32), .done(done32),
    .product_hi(hi32), .product_lo(lo32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles until the remaining Q and guard are all-equal (early exit point).
  function automatic int early_lat(input logic [63:0] q, input int w);
    logic [63:0] r;
    for (int k = 1; k < w / 2; k++) begin
      r = $signed(q) >>> (2 * k - 1);
      if (r == '0 || r == '1) return k;
    end
    return w / 2;
  endfunction

  function automatic int exp_lat(input logic [63:0] q, input int w);
`ifdef BOOTH_EARLY_EXIT_EN
    return early_lat(q, w);
`else
    return w / 2;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++;
        $display("FAIL d8_extra_done: done=1 with empty scoreboard");
      end else begin
        e = sb8.pop_front();
        check("d8_product", {48'h0, hi8, lo8}, {48'h0, e.prod[15:0]});
        check("d8_latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
    if (done32 === 1'b1) begin
      checks++;
      if (sb32.size() == 0) begin
        errors++;
        $display("FAIL d32_extra_done: done=1 with empty scoreboard");
      end else begin
        e = sb32.pop_front();
        check("d32_product", {hi32, lo32}, e.prod);
        check("d32_latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] p, input bit push);
    @(negedge clk);
    start8 = 1'b1;
    m8 = a;
    q8 = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    if (push)
      sb8.push_back('{{48'h0, p}, exp_lat({{56{b[7]}}, b}, 8), cyc});
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p);
    @(negedge clk);
    start32 = 1'b1;
    m32 = a;
    q32 = b;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    sb32.push_back('{p, exp_lat({{32{b[31]}}, b}, 32), cyc});
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy8) return;
    end
    errors++;
    $display("FAIL d8_timeout: busy=%b expected 0", busy8);
  endtask

  task automatic wait_idle32();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy32) return;
    end
    errors++;
    $display("FAIL d32_timeout: busy=%b expected 0", busy32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'h0);
    check("rst_done8", 64'(done8), 64'h0);
    check("rst_prod8", {48'h0, hi8, lo8}, 64'h0);
    check("rst_busy32", 64'(busy32), 64'h0);
    check("rst_prod32", {hi32, lo32}, 64'h0);
    clr = 1'b0;

    issue8(8'd7, 8'd3, 16'h0015, 1'b1);
    wait_idle8();
    issue8(8'h80, 8'h80, 16'h4000, 1'b1);
    wait_idle8();
    issue8(8'd127, 8'hFF, 16'hFF81, 1'b1);
    wait_idle8();
    issue8(8'h5A, 8'h00, 16'h0000, 1'b1);
    wait_idle8();
    issue8(8'hFD, 8'd5, 16'hFFF1, 1'b1);
    wait_idle8();

    issue8(8'd7, 8'd3, 16'h0015, 1'b1);
    @(negedge clk);
    start8 = 1'b1;
    m8 = 8'd5;
    q8 = 8'd5;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(negedge clk);
    check("run_start_busy8", 64'(busy8), 64'h1);
    wait_idle8();

    issue32(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    wait_idle32();
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    wait_idle32();
    issue32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    wait_idle32();
    issue32(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_idle32();
    issue32(32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);
    wait_idle32();
    issue32(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_idle32();
    issue32(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    wait_idle32();

    issue8(8'd127, 8'h80, 16'hC080, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_busy8", 64'(busy8), 64'h0);
    check("clr_done8", 64'(done8), 64'h0);
    check("clr_prod8", {48'h0, hi8, lo8}, 64'h0);
    check("clr_prod32", {hi32, lo32}, 64'h0);
    clr = 1'b0;
    issue8(8'd127, 8'hFF, 16'hFF81, 1'b1);
    wait_idle8();

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb8.size() + sb32.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
